// File: rtl/bus_port_fifo.sv
// First-word-fall-through packet queue between a host writer and a bus arbiter.
// Errors are latched into sticky overflow/underflow flags until cleared.
module bus_port_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_flags
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth+1);

  logic [pckg_sz-1:0] mem [depth];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               wr_acc;
  logic               pop_acc;
  logic               ovf_evt;
  logic               unf_evt;

  assign pndng   = (count != '0);
  assign full    = (count == CNT_W'(depth));
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_acc  = wr_en & (~full | pop);
  assign pop_acc = pop & pndng;
  assign ovf_evt = wr_en & full & ~pop;
  // A pop on an empty FIFO paired with a write is not an error: the write is simply taken.
  assign unf_evt = pop & ~pndng & ~wr_en;

  assign D_pop = pndng ? mem[rd_ptr] : '0;

  // Storage is data only and needs no reset; pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_acc && !pop_acc) begin
        count <= count + CNT_W'(1);
      end else if (pop_acc && !wr_acc) begin
        count <= count - CNT_W'(1);
      end
      overflow  <= (overflow & ~clr_flags) | ovf_evt;
      underflow <= (underflow & ~clr_flags) | unf_evt;
    end
  end

endmodule

// File: doc/bus_port_fifo.md
BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 SHALL have parameter pckg_sz, default 16: packet width in bits; upper 8 bits carry the destination id.
REQ-002 SHALL have parameter depth, default 8: number of packet slots; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1: host write strobe.
REQ-006 SHALL have port wr_data, input, pckg_sz: host packet to enqueue.
REQ-007 SHALL have port pop, input, 1: bus arbiter dequeue strobe.
REQ-008 SHALL have port D_pop, output, pckg_sz: head packet presented to the bus.
REQ-009 SHALL have port pndng, output, 1: at least one packet is stored.
REQ-010 SHALL have port full, output, 1: all depth slots are occupied.
REQ-011 SHALL have port count, output, $clog2(depth+1): number of stored packets.
REQ-012 SHALL have port overflow, output, 1: sticky flag for a write rejected because the FIFO was full.
REQ-013 SHALL have port underflow, output, 1: sticky flag for a pop received while the FIFO was empty.
REQ-014 SHALL have port clr_flags, input, 1: synchronous clear of overflow and underflow.

Function
REQ-015 SHALL be a circular buffer of depth entries with read and write pointers of $clog2(depth) bits that wrap from depth-1 to 0.
REQ-016 SHALL be first-word-fall-through: D_pop equals the head entry combinationally whenever pndng=1, with no added latency.
REQ-017 SHALL drive D_pop to all zeros whenever pndng=0.
REQ-018 SHALL assert pndng exactly when count>0 and full exactly when count==depth, both derived from registered count.
REQ-019 SHALL store wr_data and increment the write pointer on an accepted write: wr_en=1 and (full=0 or pop=1).
REQ-020 SHALL advance the read pointer on an accepted pop: pop=1 and pndng=1.
REQ-021 SHALL update count as +1 for an accepted write only, -1 for an accepted pop only, and unchanged for both or neither.
REQ-022 SHALL accept a simultaneous write and pop when full, keeping count==depth and full=1.
REQ-023 SHALL accept only the write on a simultaneous write and pop when empty; the new packet appears on D_pop the next cycle.
REQ-024 SHALL discard wr_data and set overflow on the next edge when wr_en=1, full=1 and pop=0; stored contents stay unchanged.
REQ-025 SHALL set underflow on the next edge and leave pointers and count unchanged when pop=1 and pndng=0.
REQ-026 SHALL hold overflow and underflow until reset or clr_flags; when clr_flags coincides with a new error event, the flag SHALL end set.
REQ-027 SHALL give a packet accepted in cycle N visibility on D_pop no earlier than cycle N+1.
REQ-028 SHALL not modify stored data or the destination field; the block is a pure ordered queue.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, clear both pointers, count, overflow and underflow, giving pndng=0, full=0 and D_pop=0 in the following cycle.
REQ-030 SHALL give reset priority over wr_en, pop and clr_flags in the same cycle; a reset mid-stream discards all stored packets.
REQ-031 SHALL not require the storage array to be reset.

Verification
REQ-032 SHALL be verified with: reset, write 16'h0201 then 16'h0302 -> pndng=1, count=2, D_pop=16'h0201; pop -> D_pop=16'h0302, count=1.
REQ-033 SHALL be verified with: depth=8, write 8 packets -> full=1, count=8; a 9th write with pop=0 -> overflow=1, count=8, the 9th packet is never output.
REQ-034 SHALL be verified with: FIFO full, wr_en=1 and pop=1 for 20 cycles -> count stays 8, output order matches input order, pointers wrap twice with no loss.
REQ-035 SHALL be verified with: FIFO empty, pop=1 -> underflow=1, count=0, D_pop=0; clr_flags=1 -> underflow=0 next cycle.
REQ-036 SHALL be verified with: 5 packets stored, reset=1 coinciding with wr_en=1 -> next cycle count=0, pndng=0, D_pop=0.
REQ-037 SHALL be verified with: FIFO empty, wr_en=1 with 16'hFF07 and pop=1 in the same cycle -> count=1, D_pop=16'hFF07 next cycle, underflow stays 0.
